// File: rtl/move_link_ctl.sv
// move_link_ctl: sequences one-byte MOVE/ACK frames over a shared UART link.
// Outgoing moves are sent, retried on timeout and confirmed by a matching ACK.
// Incoming moves are delivered to the game logic and acknowledged.
// The single transmitter is shared; a pending ACK always wins it first.
module move_link_ctl #(
  parameter int TIMEOUT_CYCLES = 6500000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       send_req,
  input  logic [3:0] move_square,
  input  logic       err_clr,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       busy,
  output logic       send_done,
  output logic       link_error,
  output logic       rx_move_valid,
  output logic [3:0] rx_move_square
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TX_MOVE,
    S_WAIT_ACK,
    S_ERROR
  } state_t;

  localparam logic [26:0] TIMEOUT_LAST = 27'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  RETRY_LIMIT  = 2'(MAX_RETRY);
  localparam logic [3:0]  MAX_SQUARE   = 4'd8;

  state_t      state;
  state_t      state_next;
  logic [1:0]  tx_seq;
  logic [1:0]  rx_exp_seq;
  logic [1:0]  retry_cnt;
  logic [26:0] timer;
  logic [3:0]  square_lat;
  logic        ack_pending;
  logic [1:0]  ack_seq;

  logic        rx_is_move;
  logic        rx_is_ack;
  logic [1:0]  rx_seq;
  logic [3:0]  rx_square;
  logic        rx_square_ok;
  logic        rx_accept;
  logic        rx_dup;
  logic        ack_req;
  logic        ack_launch;
  logic        move_launch;
  logic        ack_match;
  logic        timer_done;
  logic        done_next;
  logic        retry_inc;
  logic        send_accept;

  // Decode the received byte and decide which transmitter requests fire this cycle.
  always_comb begin
    rx_seq       = rx_data[5:4];
    rx_square    = rx_data[3:0];
    rx_is_move   = rx_valid && (rx_data[7:6] == 2'b01);
    rx_is_ack    = rx_valid && (rx_data[7:6] == 2'b10) && (rx_data[3:0] == 4'h0);
    rx_square_ok = (rx_square <= MAX_SQUARE);
    rx_accept    = rx_is_move && rx_square_ok && (rx_seq == rx_exp_seq);
    rx_dup       = rx_is_move && rx_square_ok && (rx_seq == (rx_exp_seq - 2'd1));
    ack_req      = rx_accept || rx_dup;
    ack_launch   = ack_pending && tx_ready && !tx_start;
    move_launch  = (state == S_TX_MOVE) && tx_ready && !tx_start && !ack_launch;
    ack_match    = (state == S_WAIT_ACK) && rx_is_ack && (rx_seq == tx_seq);
    timer_done   = (timer == TIMEOUT_LAST);
  end

  // Next-state logic for the outgoing-move sequencer; a matching ACK beats a timeout.
  always_comb begin
    state_next  = state;
    done_next   = 1'b0;
    retry_inc   = 1'b0;
    send_accept = 1'b0;
    case (state)
      S_IDLE: begin
        if (send_req && (move_square <= MAX_SQUARE)) begin
          send_accept = 1'b1;
          state_next  = S_TX_MOVE;
        end
      end
      S_TX_MOVE: begin
        if (move_launch) begin
          state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (ack_match) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else if (timer_done) begin
          if (retry_cnt < RETRY_LIMIT) begin
            retry_inc  = 1'b1;
            state_next = S_TX_MOVE;
          end else begin
            state_next = S_ERROR;
          end
        end
      end
      S_ERROR: begin
        if (err_clr) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outgoing move bookkeeping: latched square, sequence number, retry count and ACK timer.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      square_lat <= 4'd0;
      tx_seq     <= 2'd0;
      retry_cnt  <= 2'd0;
      timer      <= 27'd0;
    end else begin
      if (send_accept) begin
        square_lat <= move_square;
        retry_cnt  <= 2'd0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 2'd1;
      end
      if (ack_match) begin
        tx_seq <= tx_seq + 2'd1;
      end
      if (move_launch) begin
        timer <= 27'd0;
      end else if (state == S_WAIT_ACK && !timer_done) begin
        timer <= timer + 27'd1;
      end
    end
  end

  // Single-entry ACK queue; a fresh request overrides any launch in the same cycle.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pending <= 1'b0;
      ack_seq     <= 2'd0;
    end else begin
      if (ack_req) begin
        ack_pending <= 1'b1;
        ack_seq     <= rx_seq;
      end else if (ack_launch) begin
        ack_pending <= 1'b0;
      end
    end
  end

  // Transmitter driver; tx_data keeps the last frame between launches.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= ack_launch || move_launch;
      if (ack_launch) begin
        tx_data <= {2'b10, ack_seq, 4'b0000};
      end else if (move_launch) begin
        tx_data <= {2'b01, tx_seq, square_lat};
      end
    end
  end

  // Receive path: deliver in-order peer moves and advance the expected sequence.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_exp_seq     <= 2'd0;
      rx_move_valid  <= 1'b0;
      rx_move_square <= 4'd0;
    end else begin
      rx_move_valid <= rx_accept;
      if (rx_accept) begin
        rx_move_square <= rx_square;
        rx_exp_seq     <= rx_exp_seq + 2'd1;
      end
    end
  end

  // Registered status outputs, derived from the state being entered.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      link_error <= 1'b0;
      send_done  <= 1'b0;
    end else begin
      busy       <= (state_next != S_IDLE);
      link_error <= (state_next == S_ERROR);
      send_done  <= done_next;
    end
  end

endmodule

// File: doc/move_link_ctl.md
# move_link_ctl

Sequencer for the board-to-board UART link: turns a local move into a one-byte MOVE frame, sends it, and waits for the matching ACK. It retries on timeout and answers the peer's MOVE frames with ACKs. It arbitrates the single UART transmitter between outgoing moves and outgoing ACKs. It sits between the game control unit (move requests, received moves) and the UART TX/RX cores.

## Interface
- TIMEOUT_CYCLES, default 6500000: ACK wait per attempt, in pclk cycles (100 ms at 65 MHz).
- MAX_RETRY, default 3: resends after the first attempt before error.

- pclk  in  1  system pixel clock; only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- send_req  in  1  one-cycle request to send move_square.
- move_square  in  4  square index 0..8.
- err_clr  in  1  clears ERROR state.
- tx_ready  in  1  UART TX idle, accepts tx_start.
- tx_start  out  1  one-cycle transmit strobe.
- tx_data  out  8  frame byte; valid while tx_start=1.
- rx_valid  in  1  one-cycle strobe, byte received.
- rx_data  in  8  received byte.
- busy  out  1  a move is in flight or the block is in ERROR.
- send_done  out  1  one-cycle pulse when the matching ACK arrives.
- link_error  out  1  high while in ERROR.
- rx_move_valid  out  1  one-cycle pulse for a new peer move.
- rx_move_square  out  4  peer square; holds until the next rx_move_valid.

## Operation
- Frame format:
  - MOVE = {2'b01, seq[1:0], square[3:0]}.
  - ACK = {2'b10, seq[1:0], 4'b0000}.
  - Any other byte is dropped.
- Registers: tx_seq (2b), rx_exp_seq (2b), retry_cnt (2b), timer (27b), latched square, ack_pending, ack_seq.
- TX FSM states: IDLE, TX_MOVE, WAIT_ACK, ERROR.
- IDLE:
  - send_req with move_square ≤ 8 latches the square, sets retry_cnt=0, and goes to TX_MOVE.
  - move_square > 8 is ignored.
  - send_req outside IDLE is ignored.
- TX_MOVE: when tx_ready=1 and no ACK is being launched this cycle, pulse tx_start with the MOVE{tx_seq, square}, clear timer, and go to WAIT_ACK.
- WAIT_ACK:
  - ACK with seq == tx_seq: send_done pulse, tx_seq += 1 (wraps 3→0), go to IDLE.
  - ACK with any other seq: ignored.
  - timer == TIMEOUT_CYCLES-1 and retry_cnt < MAX_RETRY: retry_cnt += 1, go to TX_MOVE (same seq and square).
  - timer == TIMEOUT_CYCLES-1 and retry_cnt == MAX_RETRY: go to ERROR.
- ERROR:
  - link_error=1 and busy=1.
  - err_clr goes to IDLE; tx_seq is unchanged.
  - The RX/ACK path keeps running.
- RX path, active in every state:
  - MOVE with square ≤ 8 and seq == rx_exp_seq: rx_move_square=square, rx_move_valid pulse, rx_exp_seq += 1, queue an ACK(seq).
  - MOVE with seq == rx_exp_seq-1 (duplicate from a lost ACK): queue an ACK(seq) only.
  - Other MOVE seq, or square > 8: dropped.
- ACK queue:
  - Single entry: ack_pending with ack_seq.
  - A new queue request overwrites ack_seq.
- TX arbitration:
  - A pending ACK has priority over a MOVE when both are eligible in the same cycle.
  - An ACK launches whenever tx_ready=1 and no tx_start was issued in the previous cycle. tx_ready may lag one cycle.
  - An ACK launch clears ack_pending.
- A received ACK frame never queues an ACK.

## Timing
- All outputs are registered.
- Reset values: tx_start=0, tx_data=0, busy=0, send_done=0, link_error=0, rx_move_valid=0, rx_move_square=0. All internal registers are 0 and the FSM is in IDLE.
- send_req at edge N gives busy=1 after edge N. The earliest tx_start is high after edge N+1 (when tx_ready=1 and no ACK is pending).
- rx_valid MOVE at edge N gives rx_move_valid high after edge N.
- A queued ACK's tx_start is high no earlier than after edge N+1.
- ACK match at edge N gives send_done high and busy=0 after edge N, unless that ACK is launching in the same cycle.
- tx_start is never high on two consecutive cycles. tx_data holds its value until the next launch.
- ACK match and timeout on the same edge: the ACK wins (send_done, no retry).
- err_clr and ACK in ERROR: the ACK is ignored.
- rst_n low mid-transfer drops everything at once, with no tx_start glitch.

## Test plan
- Loopback peer returns ACK(0) 100 cycles after MOVE: send_req with square=4 → tx_data=0x44, one send_done, tx_seq=1, busy falls.
- No ACK, TIMEOUT_CYCLES=50, MAX_RETRY=3 → four 0x44 strobes spaced about 50 cycles apart, then link_error=1. err_clr → IDLE with link_error=0.
- Inject rx 0x47, then 0x47 again → one rx_move_valid with square=7, and two ACK bytes 0x80 transmitted. An out-of-window frame 0x67 (seq 2 while expecting 1) is dropped with no ACK.
- Collision: send_req and rx MOVE 0x43 arrive on the same cycle with tx_ready=1 → ACK 0x80 is sent before MOVE 0x40, and no back-to-back tx_start occurs.
- Four completed sends → tx_seq wraps 3→0. The fifth MOVE carries seq 0 (byte 0x4X).
- Assert rst_n low during WAIT_ACK → all outputs are 0 immediately. After release, a send_req uses seq 0.
